// File: rtl/exu_cal_arb.sv
// exu_cal_arb: two-requester arbiter and one-entry response buffer placed in
// front of the shared exu_cal unit. Requester 0 is the EX pipeline and
// requester 1 is a secondary client. The arbiter grants the cal unit to one
// requester per cycle, captures the combinational cal result one cycle later,
// and returns it to the granted requester on a val/rdy response channel.
module exu_cal_arb #(
  parameter int OPB_W      = 72,
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_LIM = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_r04arb_val,
  output logic             hs_arb4r0_rdy,
  input  logic [OPB_W-1:0] r0_opb,
  input  logic             hs_r14arb_val,
  output logic             hs_arb4r1_rdy,
  input  logic [OPB_W-1:0] r1_opb,
  output logic             hs_arb4cal_val,
  input  logic             hs_cal4arb_rdy,
  output logic [OPB_W-1:0] o_opb,
  input  logic [31:0]      cal_res,
  output logic             hs_arb4r0_rsp_val,
  input  logic             hs_r04arb_rsp_rdy,
  output logic             hs_arb4r1_rsp_val,
  input  logic             hs_r14arb_rsp_rdy,
  output logic [31:0]      rsp_data
);

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  logic [31:0] r_rspData;
  logic        r_rspVld;
  logic        r_rspId;
  logic        r_lastGnt;
  logic [7:0]  r_starveCnt;

  logic w_drain;
  logic w_canIssue;
  logic w_gnt;
  logic w_fire;

  // The buffer frees up this cycle when its owner takes the response, which
  // lets a new operation issue back-to-back without a bubble.
  assign w_drain    = r_rspVld & (r_rspId ? hs_r14arb_rsp_rdy : hs_r04arb_rsp_rdy);
  assign w_canIssue = (~r_rspVld | w_drain) & hs_cal4arb_rdy;

  // Pick the winner: a lone requester always wins; on a tie use round-robin
  // or fixed priority, where a starved requester 1 is forced through once.
  always_comb begin
    w_gnt = 1'b0;
    if (hs_r04arb_val && hs_r14arb_val) begin
      if (PRIO_MODE == 0) begin
        w_gnt = ~r_lastGnt;
      end else begin
        w_gnt = (r_starveCnt == LIM);
      end
    end else if (hs_r14arb_val) begin
      w_gnt = 1'b1;
    end
  end

  assign hs_arb4cal_val = (hs_r04arb_val | hs_r14arb_val) & w_canIssue;
  assign w_fire         = hs_arb4cal_val & hs_cal4arb_rdy;
  assign hs_arb4r0_rdy  = ~w_gnt & w_canIssue & hs_r04arb_val;
  assign hs_arb4r1_rdy  = w_gnt & w_canIssue & hs_r14arb_val;

  // Only present an operation to the cal unit while it is actually issuing,
  // so an idle or stalled arbiter shows a clean all-zero bundle.
  always_comb begin
    o_opb = '0;
    if (hs_arb4cal_val) begin
      o_opb = w_gnt ? r1_opb : r0_opb;
    end
  end

  assign hs_arb4r0_rsp_val = r_rspVld & ~r_rspId;
  assign hs_arb4r1_rsp_val = r_rspVld & r_rspId;
  assign rsp_data          = r_rspData;

  // Response buffer: a fire overwrites it (even while it drains), a drain
  // alone only clears the valid bit so the data stays visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rspData <= '0;
      r_rspVld  <= 1'b0;
      r_rspId   <= 1'b0;
      r_lastGnt <= 1'b1;
    end else if (w_fire) begin
      r_rspData <= cal_res;
      r_rspVld  <= 1'b1;
      r_rspId   <= w_gnt;
      r_lastGnt <= w_gnt;
    end else if (w_drain) begin
      r_rspVld  <= 1'b0;
    end
  end

  // Starvation counter for requester 1 in fixed-priority mode; stalled
  // cycles are not counted because nobody could have been served then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (PRIO_MODE == 0) begin
      r_starveCnt <= '0;
    end else if (!hs_r14arb_val || (w_fire && w_gnt)) begin
      r_starveCnt <= '0;
    end else if (w_canIssue && (r_starveCnt != LIM)) begin
      r_starveCnt <= r_starveCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_exu_cal_arb.sv
// Randomized bench for exu_cal_arb. Two instances share the requester
// stimulus: one in round-robin mode and one in fixed-priority mode with a
// starvation limit of 4. A stand-in cal unit adds the two low operand words.
module tb_exu_cal_arb;

  localparam int OPB_W  = 72;
  localparam int LIM    = 4;
  localparam int CYCLES = 4000;

  logic             clk;
  logic             rst_n;
  logic             r0Val, r1Val, calRdy, r0RspRdy, r1RspRdy;
  logic [OPB_W-1:0] r0Opb, r1Opb;

  logic             r0Rdy[2], r1Rdy[2], calVal[2], r0RspVal[2], r1RspVal[2];
  logic [OPB_W-1:0] oOpb[2];
  logic [31:0]      calRes[2], rspData[2];

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;

  // Reference state, one set per instance: 0 = round-robin, 1 = fixed priority
  bit      mVld[2];
  bit      mOwner[2];
  int      mData[2];
  bit      mLastWinner[2];
  int      mStarve[2];

  function automatic logic [31:0] calcRes(input logic [OPB_W-1:0] opb);
    return opb[31:0] + opb[63:32];
  endfunction

  assign calRes[0] = calcRes(oOpb[0]);
  assign calRes[1] = calcRes(oOpb[1]);

  exu_cal_arb #(.OPB_W(OPB_W), .PRIO_MODE(0), .STARVE_LIM(8)) dutRr (
    .clk(clk), .rst_n(rst_n),
    .hs_r04arb_val(r0Val), .hs_arb4r0_rdy(r0Rdy[0]), .r0_opb(r0Opb),
    .hs_r14arb_val(r1Val), .hs_arb4r1_rdy(r1Rdy[0]), .r1_opb(r1Opb),
    .hs_arb4cal_val(calVal[0]), .hs_cal4arb_rdy(calRdy), .o_opb(oOpb[0]),
    .cal_res(calRes[0]),
    .hs_arb4r0_rsp_val(r0RspVal[0]), .hs_r04arb_rsp_rdy(r0RspRdy),
    .hs_arb4r1_rsp_val(r1RspVal[0]), .hs_r14arb_rsp_rdy(r1RspRdy),
    .rsp_data(rspData[0])
  );

  exu_cal_arb #(.OPB_W(OPB_W), .PRIO_MODE(1), .STARVE_LIM(LIM)) dutFp (
    .clk(clk), .rst_n(rst_n),
    .hs_r04arb_val(r0Val), .hs_arb4r0_rdy(r0Rdy[1]), .r0_opb(r0Opb),
    .hs_r14arb_val(r1Val), .hs_arb4r1_rdy(r1Rdy[1]), .r1_opb(r1Opb),
    .hs_arb4cal_val(calVal[1]), .hs_cal4arb_rdy(calRdy), .o_opb(oOpb[1]),
    .cal_res(calRes[1]),
    .hs_arb4r0_rsp_val(r0RspVal[1]), .hs_r04arb_rsp_rdy(r0RspRdy),
    .hs_arb4r1_rsp_val(r1RspVal[1]), .hs_r14arb_rsp_rdy(r1RspRdy),
    .rsp_data(rspData[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [OPB_W-1:0] observed,
                             input logic [OPB_W-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [OPB_W-1:0] randOpb();
    return {8'($urandom), 32'($urandom_range(0, 1000)), 32'($urandom_range(0, 1000))};
  endfunction

  // Modes: 0 fully random, 1 both requesters hammering with everything ready,
  // 2 both requesting with sparse response ready, 3 random with cal stalls
  task automatic applyStimulus();
    bit both;
    both = (mode == 1) || (mode == 2);
    rst_n    = ($urandom_range(0, 199) != 0);
    r0Val    = both ? 1'b1 : 1'($urandom);
    r1Val    = both ? 1'b1 : 1'($urandom);
    calRdy   = (mode == 3) ? ($urandom_range(0, 2) == 0) : (mode == 1) ? 1'b1 : ($urandom_range(0, 7) != 0);
    r0RspRdy = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
    r1RspRdy = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
    r0Opb    = randOpb();
    r1Opb    = randOpb();
  endtask

  // Compare one instance against the rules, then advance its reference state
  // to what it should hold after the coming clock edge.
  task automatic checkAndStep(input int k);
    bit takeRsp, freeSlot, winner, issue;
    logic [OPB_W-1:0] expOpb;
    string sfx;
    sfx = (k == 0) ? "rr" : "fp";

    takeRsp  = mVld[k] && (mOwner[k] ? r1RspRdy : r0RspRdy);
    freeSlot = (!mVld[k] || takeRsp) && calRdy;

    if (r0Val && r1Val) begin
      if (k == 0) winner = !mLastWinner[k];
      else        winner = (mStarve[k] == LIM);
    end else begin
      winner = r1Val;
    end
    issue  = (r0Val || r1Val) && freeSlot;
    expOpb = issue ? (winner ? r1Opb : r0Opb) : '0;

    if (rst_n) begin
      checkOutput({"cal_val_", sfx}, OPB_W'(calVal[k]), OPB_W'(issue));
      checkOutput({"r0_rdy_", sfx},  OPB_W'(r0Rdy[k]),  OPB_W'(issue && !winner));
      checkOutput({"r1_rdy_", sfx},  OPB_W'(r1Rdy[k]),  OPB_W'(issue && winner));
      checkOutput({"o_opb_", sfx},   oOpb[k],           expOpb);
      checkOutput({"r0_rsp_val_", sfx}, OPB_W'(r0RspVal[k]), OPB_W'(mVld[k] && !mOwner[k]));
      checkOutput({"r1_rsp_val_", sfx}, OPB_W'(r1RspVal[k]), OPB_W'(mVld[k] && mOwner[k]));
      checkOutput({"rsp_data_", sfx},   OPB_W'(rspData[k]),  OPB_W'(32'(mData[k])));
    end

    if (!rst_n) begin
      mVld[k] = 0; mOwner[k] = 0; mData[k] = 0; mLastWinner[k] = 1; mStarve[k] = 0;
    end else begin
      if (issue) begin
        mData[k] = int'(calcRes(expOpb));
        mOwner[k] = winner; mVld[k] = 1; mLastWinner[k] = winner;
      end else if (takeRsp) begin
        mVld[k] = 0;
      end
      if (k == 1) begin
        if (!r1Val || (issue && winner)) mStarve[k] = 0;
        else if (freeSlot && mStarve[k] < LIM) mStarve[k] = mStarve[k] + 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; r0Val = 0; r1Val = 0; calRdy = 0; r0RspRdy = 0; r1RspRdy = 0;
    r0Opb = '0; r1Opb = '0;
    for (int k = 0; k < 2; k++) begin
      mVld[k] = 0; mOwner[k] = 0; mData[k] = 0; mLastWinner[k] = 1; mStarve[k] = 0;
    end
    repeat (2) @(posedge clk);

    // Reset state with nothing requesting, then a first tie that r0 must win
    @(negedge clk);
    rst_n = 1'b1; calRdy = 1'b1;
    #2;
    checkAndStep(0);
    checkAndStep(1);
    @(negedge clk);
    r0Val = 1'b1; r1Val = 1'b1; r0Opb = randOpb(); r1Opb = randOpb();
    #2;
    checkOutput("first_tie_r0_rr", OPB_W'(r0Rdy[0]), OPB_W'(1'b1));
    checkOutput("first_tie_r0_fp", OPB_W'(r0Rdy[1]), OPB_W'(1'b1));
    checkAndStep(0);
    checkAndStep(1);

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      if (c % 40 == 0) mode = $urandom_range(0, 3);
      applyStimulus();
      #2;
      checkAndStep(0);
      checkAndStep(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exu_cal_arb.md
Name: exu_cal_arb

Overview:
- Two-requester arbiter and result buffer in front of the shared exu_cal unit.
- Requester 0 is the EX pipeline. Requester 1 is a secondary client such as the branch/address or CSR path.
- Grants the cal unit to one requester per cycle, registers the combinational cal result into a one-entry response buffer, and returns it to the granted requester on a val/rdy response channel.
- Provides round-robin or fixed-priority arbitration, with starvation protection in fixed-priority mode.

Parameters:
- OPB_W, 72, width of the cal operation bundle; always set to `CIRNO_CAL_OPB_SIZE at instantiation.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with requester 0 highest.
- STARVE_LIM, 8, consecutive denied cycles for requester 1 before a forced grant (PRIO_MODE=1 only); legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- hs_r04arb_val  in  1  requester 0 request valid
- hs_arb4r0_rdy  out  1  requester 0 request accepted
- r0_opb  in  OPB_W  requester 0 operation bundle
- hs_r14arb_val  in  1  requester 1 request valid
- hs_arb4r1_rdy  out  1  requester 1 request accepted
- r1_opb  in  OPB_W  requester 1 operation bundle
- hs_arb4cal_val  out  1  to exu_cal hs_ex4cal_val
- hs_cal4arb_rdy  in  1  from exu_cal ready
- o_opb  out  OPB_W  to exu_cal i_opb
- cal_res  in  32  exu_cal res, combinational, same cycle as o_opb
- hs_arb4r0_rsp_val  out  1  response valid to requester 0
- hs_r04arb_rsp_rdy  in  1  requester 0 takes response
- hs_arb4r1_rsp_val  out  1  response valid to requester 1
- hs_r14arb_rsp_rdy  in  1  requester 1 takes response
- rsp_data  out  32  response data, shared by both requesters

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rst_n, sampled at the clk rising edge.
- Reset state:
  - rsp_vld=0, rsp_id=0, rsp_data=0.
  - last_gnt=1, so requester 0 wins the first tie.
  - starve_cnt=0.
  - All handshake outputs 0. o_opb=0.
- Reset mid-operation: a buffered, undelivered response is discarded. Requesters re-issue.
- Response buffer drain: rsp_drain = rsp_vld & (rsp_id ? hs_r14arb_rsp_rdy : hs_r04arb_rsp_rdy).
- Issue condition: can_issue = (!rsp_vld | rsp_drain) & hs_cal4arb_rdy.
- Arbitration, combinational each cycle:
  - Only one valid requester: it is granted.
  - Both valid, PRIO_MODE=0: grant = !last_gnt.
  - Both valid, PRIO_MODE=1: grant 0, unless starve_cnt==STARVE_LIM, in which case grant 1.
- Handshake outputs:
  - hs_arb4cal_val = (r0 val | r1 val) & can_issue.
  - hs_arb4rN_rdy = grantN & can_issue.
  - At most one rdy high per cycle.
- o_opb: the granted requester's opb while hs_arb4cal_val=1; otherwise all zeros.
- Fire (hs_arb4cal_val & hs_cal4arb_rdy), registered at the next edge:
  - rsp_data <= cal_res, rsp_id <= grant, rsp_vld <= 1, last_gnt <= grant.
- Latency: exactly 1 cycle from request fire to rsp_val.
- Throughput: 1 op/cycle when the response is drained every cycle.
- Simultaneous drain and fire: the buffer is overwritten with the new result and rsp_vld stays 1. This is legal in the same cycle even when both belong to the same requester.
- Drain without fire: rsp_vld <= 0. rsp_data holds its value.
- Full buffer, not draining: no grant, both rdy=0, o_opb=0. Requests hold. Requesters keep val and opb stable until their rdy.
- Starvation counter (PRIO_MODE=1):
  - Increments while hs_r14arb_val=1 and r1 is not fired. Saturates at STARVE_LIM.
  - Clears to 0 on r1 fire or when hs_r14arb_val=0.
  - Counts only when can_issue=1, so stalled cycles are not counted.
  - Unused (held 0) when PRIO_MODE=0.
- Response outputs: hs_arb4rN_rsp_val = rsp_vld & (rsp_id==N).
- Flop count: one 32-bit data register, valid, id, last_gnt, and an 8-bit counter.

Test Plan:
- Single request: r0 only, opb ADD opn1=5 opn2=3 → hs_arb4r0_rdy=1 same cycle; next cycle hs_arb4r0_rsp_val=1, rsp_data=8; r1 rdy and r1 rsp_val stay 0.
- Round-robin (PRIO_MODE=0): r0 (SUB 10−4) and r1 (XOR 0xF0^0x0F) both held valid, rsp_rdy tied 1 → grants r0, r1, r0, r1 on consecutive cycles; responses 6 then 0xFF alternate with matching rsp_val.
- Back-pressure: r0 fires, hs_r04arb_rsp_rdy=0 for 3 cycles while r1 valid → both rdy=0 and o_opb=0 for 3 cycles; rsp_data held at r0 result; r1 fires in the cycle rsp_rdy returns to 1 and responds the following cycle.
- Starvation (PRIO_MODE=1, STARVE_LIM=4): r0 and r1 continuously valid, rsp_rdy=1 → r0 granted 4 cycles, r1 on the 5th, then the counter restarts at 0.
- Cal stall: hs_cal4arb_rdy=0 for 2 cycles with r0 valid → no rdy, no response, starve_cnt frozen; fires on the first cycle ready=1.
- Reset mid-op: rst_n=0 for 1 cycle while rsp_vld=1 → next cycle all rsp_val=0, rsp_data=0; first tie afterwards grants r0.
